// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer.
// Contents: data width, opcode constants, sequencer state encoding,
// write-data and AC operation selects, and the opcode dispatch helper.
package cpu_pkg;

    // Address/data width; IR field positions assume 12 bits.
    localparam int W = 12;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    localparam logic [1:0] WSEL_AC  = 2'd0;
    localparam logic [1:0] WSEL_INC = 2'd1;
    localparam logic [1:0] WSEL_PC  = 2'd2;

    localparam logic [1:0] AC_NONE = 2'd0;
    localparam logic [1:0] AC_AND  = 2'd1;
    localparam logic [1:0] AC_ADD  = 2'd2;
    localparam logic [1:0] AC_CLR  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_IND    = 3'd3,
        S_OPRD   = 3'd4,
        S_OPWR   = 3'd5,
        S_JMS2   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // State that follows once the effective address is final.
    // JMP lands in FETCH; the caller adds pc_ld_ma for it.
    function automatic state_t dispatch(input logic [2:0] op);
        case (op)
            OP_AND, OP_TAD, OP_ISZ: dispatch = S_OPRD;
            OP_DCA, OP_JMS:         dispatch = S_OPWR;
            OP_OPR:                 dispatch = S_HALT;
            default:                dispatch = S_FETCH;
        endcase
    endfunction

    // Write-data source used by each memory-writing opcode.
    function automatic logic [1:0] wsel_for(input logic [2:0] op);
        case (op)
            OP_ISZ:  wsel_for = WSEL_INC;
            OP_JMS:  wsel_for = WSEL_PC;
            default: wsel_for = WSEL_AC;
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_ctrl.sv
// Fetch/execute sequencer for the 12-bit PDP-8-style accumulator CPU.
// Drives the address mux, the memory request/write handshake and the
// one-cycle load/increment strobes for IR, MA, MDR, PC and AC.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   run                  start/resume, honoured only in IDLE and HALT
//   ir_op, ir_ind        opcode IR[11:9] and indirect bit IR[8]
//   mem_ack              memory transfer completes this cycle
//   inc_zero             datapath flag MDR+1 == 0 (ISZ skip)
//   addr_sel             0 = PC, 1 = MA
//   mem_req, mem_we      memory request and write enable
//   wdata_sel            0 AC, 1 MDR+1, 2 PC
//   ir_ld .. pc_ld_ma    datapath load/increment strobes
//   ac_op                0 none, 1 AND MDR, 2 ADD MDR, 3 clear
//   halted               high in HALT
//
// state  | meaning
// IDLE   | waiting for run after reset
// FETCH  | read instruction at PC; IR load and PC+1 on ack
// DECODE | load MA from IR, pick indirect or operand path
// IND    | read pointer at MA; MA <= mem data on ack
// OPRD   | read operand at MA into MDR
// OPWR   | write AC / MDR+1 / PC to MA
// JMS2   | PC <= MA+1 after JMS stores the return address
// HALT   | stopped, waiting for run
module mem_seq_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] ir_op,
    input  logic       ir_ind,
    input  logic       mem_ack,
    input  logic       inc_zero,
    output logic       addr_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] wdata_sel,
    output logic       ir_ld,
    output logic       ma_ld_ir,
    output logic       ma_ld_mem,
    output logic       mdr_ld,
    output logic       pc_inc,
    output logic       pc_ld_ma,
    output logic [1:0] ac_op,
    output logic       halted
);

    state_t     state, state_n;
    // post_ind: DECODE is being revisited after an indirect JMP; MA is
    // already final, so skip the IR address load and any further indirection.
    logic       post_ind, post_ind_n;
    // ac_pend: AC operation deferred to the cycle after the operand read.
    logic [1:0] ac_pend, ac_pend_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            post_ind <= 1'b0;
            ac_pend  <= AC_NONE;
        end else begin
            state    <= state_n;
            post_ind <= post_ind_n;
            ac_pend  <= ac_pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        post_ind_n = 1'b0;
        ac_pend_n  = AC_NONE;
        case (state)
            S_IDLE:   if (run) state_n = S_FETCH;
            S_FETCH:  if (mem_ack) state_n = S_DECODE;
            S_DECODE: begin
                if (!post_ind && ir_ind && (ir_op < OP_IOT))
                    state_n = S_IND;
                else
                    state_n = dispatch(ir_op);
            end
            S_IND: begin
                if (mem_ack) begin
                    if (ir_op == OP_JMP) begin
                        state_n    = S_DECODE;
                        post_ind_n = 1'b1;
                    end else begin
                        state_n = dispatch(ir_op);
                    end
                end
            end
            S_OPRD: begin
                if (mem_ack) begin
                    if (ir_op == OP_ISZ) begin
                        state_n = S_OPWR;
                    end else begin
                        state_n   = S_FETCH;
                        ac_pend_n = (ir_op == OP_AND) ? AC_AND : AC_ADD;
                    end
                end
            end
            S_OPWR: begin
                if (mem_ack) state_n = (ir_op == OP_JMS) ? S_JMS2 : S_FETCH;
            end
            S_JMS2:   state_n = S_FETCH;
            S_HALT:   if (run) state_n = S_FETCH;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        addr_sel  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wdata_sel = WSEL_AC;
        ir_ld     = 1'b0;
        ma_ld_ir  = 1'b0;
        ma_ld_mem = 1'b0;
        mdr_ld    = 1'b0;
        pc_inc    = 1'b0;
        pc_ld_ma  = 1'b0;
        ac_op     = AC_NONE;
        halted    = 1'b0;
        // Reset blanks everything in the same cycle so a transfer that is
        // acked while rst is high produces no strobes.
        if (!rst) begin
            ac_op = ac_pend;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_ld   = mem_ack;
                    pc_inc  = mem_ack;
                end
                S_DECODE: begin
                    ma_ld_ir = !post_ind && (ir_op < OP_IOT);
                    pc_ld_ma = (ir_op == OP_JMP) && (post_ind || !ir_ind);
                end
                S_IND: begin
                    addr_sel  = 1'b1;
                    mem_req   = 1'b1;
                    ma_ld_mem = mem_ack;
                end
                S_OPRD: begin
                    addr_sel = 1'b1;
                    mem_req  = 1'b1;
                    mdr_ld   = mem_ack;
                end
                S_OPWR: begin
                    addr_sel  = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    wdata_sel = wsel_for(ir_op);
                    if (mem_ack && ir_op == OP_DCA) ac_op = AC_CLR;
                    if (mem_ack && ir_op == OP_ISZ) pc_inc = inc_zero;
                end
                S_JMS2: begin
                    // Both high: the datapath loads PC <= MA+1.
                    pc_ld_ma = 1'b1;
                    pc_inc   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Fetch/execute sequencer for the 12-bit accumulator CPU.
- Drives the PC/MA address-mux select, the memory request/write handshake, and load/increment strobes for IR, MA, MDR, PC and AC.
- Implements the 8-opcode PDP-8-style instruction set.
- Sits between the memory port and the datapath registers.

Parameters:
- W, 12, address/data width; IR field positions assume 12.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  start/resume pulse; sampled in IDLE and HALT
- ir_op  in  3  IR[11:9] opcode
- ir_ind  in  1  IR[8] indirect bit
- mem_ack  in  1  memory transfer complete this cycle
- inc_zero  in  1  datapath flag: MDR+1 == 0
- addr_sel  out  1  address mux select: 0 = PC, 1 = MA
- mem_req  out  1  memory request
- mem_we  out  1  write enable, valid with mem_req
- wdata_sel  out  2  write data: 0 AC, 1 MDR+1, 2 PC
- ir_ld  out  1  IR <= mem data
- ma_ld_ir  out  1  MA <= effective address from IR page/offset
- ma_ld_mem  out  1  MA <= mem data (indirect)
- mdr_ld  out  1  MDR <= mem data
- pc_inc  out  1  PC <= PC+1
- pc_ld_ma  out  1  PC <= MA
- ac_op  out  2  0 none, 1 AND MDR, 2 ADD MDR, 3 clear
- halted  out  1  high in HALT

Behaviour:
- One state register, encoded as IDLE, FETCH, DECODE, IND, OPRD, OPWR, JMS2, HALT.
- Outputs are combinational from state plus inputs.
- Strobes are qualified by mem_ack in memory states, so each strobe is exactly one cycle.
- Reset: state IDLE; all outputs 0, including addr_sel=0 and halted=0.
  - rst wins over every other input.
  - rst asserted mid-transfer drops mem_req at the next edge. No partial strobes are issued after that edge.
- IDLE: no outputs. run=1 -> FETCH.
- FETCH:
  - Drives addr_sel=0, mem_req=1, mem_we=0.
  - Holds until mem_ack. On the ack cycle: ir_ld=1, pc_inc=1, then -> DECODE.
- DECODE (1 cycle):
  - Opcodes 0-5: ma_ld_ir=1. If ir_ind=1 -> IND.
  - Otherwise dispatch:
    - op 0/1/2 -> OPRD
    - op 3 -> OPWR with wdata_sel=0
    - op 4 -> OPWR with wdata_sel=2
    - op 5 -> pc_ld_ma=1, then FETCH
    - op 6 (NOP) -> FETCH
    - op 7 -> HALT
- IND:
  - Drives addr_sel=1, mem_req=1, read.
  - On ack: ma_ld_mem=1, then dispatch by op exactly as in DECODE.
  - Op 5 asserts pc_ld_ma in the cycle after the ack, using a single JMS2-style pass through DECODE logic. No second indirection is ever taken.
- OPRD:
  - Drives addr_sel=1, mem_req=1, read.
  - On ack: mdr_ld=1.
    - op0: ac_op=1 next cycle, via a 1-cycle pass through DECODE-free EXEC inside OPRD exit.
    - op1: ac_op=2.
    - Both then -> FETCH.
    - op2 -> OPWR with wdata_sel=1.
  - ac_op is asserted in the cycle after the ack.
- OPWR:
  - Drives addr_sel=1, mem_req=1, mem_we=1, wdata_sel held stable until ack.
  - On ack:
    - op3: ac_op=3 -> FETCH.
    - op2: pc_inc=inc_zero (skip) -> FETCH.
    - op4 -> JMS2.
- JMS2 (1 cycle): pc_ld_ma=1 -> FETCH.
  - Sequencing for the PC: the cycle after JMS2 is FETCH, whose address sees PC=MA. The datapath applies pc_inc before FETCH via JMS2 asserting pc_ld_ma and pc_inc together. The datapath gives PC <= MA+1 when both are high.
- HALT: halted=1, no requests. run=1 -> FETCH.
- Invariants:
  - mem_req, addr_sel, mem_we and wdata_sel are stable from request until the ack cycle inclusive.
  - mem_ack with mem_req=0 is ignored.
  - run outside IDLE/HALT is ignored.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants OP_AND..OP_OPR
  - state encoding
  - WSEL_AC/WSEL_INC/WSEL_PC
  - AC_NONE/AND/ADD/CLR
- No sub-module is needed: single FSM with next-state and output blocks.

Test Plan:
- Reset: rst=1 for 2 cycles during FETCH with mem_req=1 -> next cycle all outputs 0, state IDLE, run ignored while rst=1.
- TAD direct, ir_op=1, ir_ind=0, mem_ack after 0 and 3 wait cycles:
  - FETCH: ir_ld and pc_inc pulse once.
  - DECODE: ma_ld_ir.
  - OPRD: addr_sel=1, mdr_ld on ack; ac_op=2 one cycle later.
  - Total 4 cycles with zero-wait memory.
- ISZ, op2, inc_zero=1 -> OPWR with mem_we=1 and wdata_sel=1, pc_inc on write ack; repeat with inc_zero=0 -> no pc_inc.
- JMP indirect, op5, ir_ind=1 -> IND read, ma_ld_mem, then pc_ld_ma, then FETCH with addr_sel=0; exactly one memory read in IND.
- JMS, op4 -> OPWR with wdata_sel=2, then JMS2 with pc_ld_ma=1 and pc_inc=1, then FETCH.
- HLT, op7 -> halted=1 and mem_req=0 held for 10 cycles; run pulse -> FETCH next cycle, halted=0.
